regbank_writeback_ctrl: RTL and testbench
=========================================

Name: regbank_writeback_ctrl

Overview:
- Write-side controller for the 32-bit ARM register bank.
- Accepts completed results from two pipeline producers:
  - the ALU channel;
  - the load/store channel, with optional base-register writeback.
- Arbitrates them onto the bank's two GPR write ports, the PC update port and the CSPR update port.
- All bank-facing outputs are registered, so the bank sees one clean write set per clock.

Parameters:
- N, 32, datapath width.
- STARVE_MAX, 4, consecutive ALU stall cycles before the ALU is forced to win arbitration.

Ports:
- clk  in  1  system clock; bank write strobes sampled on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle; combinational.
- alu_rd  in  4  ALU destination register.
- alu_data  in  N  ALU result.
- alu_wb  in  1  ALU result writes a register.
- alu_flags_we  in  1  ALU updates flags.
- alu_flags  in  4  NZCV.
- ld_valid  in  1  load result valid.
- ld_ready  out  1  load result accepted; combinational.
- ld_rd  in  4  load destination register.
- ld_data  in  N  load data.
- ld_base_we  in  1  post-index base writeback requested.
- ld_base_rd  in  4  base register.
- ld_base_data  in  N  updated base value.
- cspr  in  N  current CSPR from the bank.
- write_address, write_data, write_enable  out  4/N/1  bank port 1.
- write_address2, write_data2, write_enable2  out  4/N/1  bank port 2.
- pc_update, pc_write  out  N/1  PC write.
- cspr_update, cspr_write  out  N/1  CSPR write.
- flush  out  1  one-cycle pulse, concurrent with pc_write.

Behaviour:
- Reset (async, rst_n low): all enables, flush, data and address outputs = 0; starvation counter = 0.
- Reset is effective immediately mid-operation; transactions in flight are dropped.
- Latency:
  - A transaction accepted in cycle T (valid & ready high at edge T) drives its bank outputs during cycle T+1.
  - Enables are single-cycle pulses.
- Handshake:
  - ready may depend on valid.
  - A producer holds its payload stable until accepted.
  - A valid=0 cycle produces no writes.
- Slot demand per accepted transaction:
  - Load: 1 slot, or 2 if ld_base_we.
  - ALU: 1 slot if alu_wb, else 0. An ALU flags-only result always fits.
- Any destination equal to 15 is routed to pc_update/pc_write (and flush) instead of a GPR port and consumes no GPR slot.
- Load plus base, both targeting 15: ld_data wins the PC.
- Arbitration, normal mode (load has priority):
  - Load is accepted whenever ld_valid.
  - ALU is accepted if the remaining GPR slots suffice, no PC conflict exists, and alu_rd differs from every load destination.
  - On a same-register conflict, the load writes first and the ALU writes in a later cycle, preserving program order (ALU is younger).
- Port assignment:
  - Load data goes to port 1; base goes to port 2.
  - With no base writeback, ALU goes to port 2.
  - If no load is accepted, ALU goes to port 1.
- Starvation counter:
  - Increments on each cycle with alu_valid=1 and alu_ready=0; saturates at STARVE_MAX.
  - Clears when the ALU is accepted.
  - When the count equals STARVE_MAX, the priorities swap for that cycle: ALU is accepted and the load is accepted only if it fits.
- Flags:
  - cspr_update = {alu_flags, cspr[N-5:0]}, sampled at acceptance.
  - cspr_write = 1 on the next cycle.
- Simultaneous PC writes from both channels cannot occur: the younger (ALU) is stalled.

Optional Feature:
- Macro WBCTRL_BYPASS_EN.
- When defined, adds three ports:
  - byp_addr  in  4
  - byp_hit  out  1
  - byp_data  out  N
- byp_hit=1 when byp_addr matches an enabled registered write on port 1 or port 2 (port 2 takes precedence); byp_data returns that data, otherwise 0.
- This lets the decode stage forward values that the bank will commit this cycle.
- Without the macro: the ports are absent and there is no bypass logic.

Test Plan:
- Reset, then ALU alone writing r3=0x0000000A -> next cycle write_enable=1, write_address=3, write_data=0xA, write_enable2=0.
- Load r1=0x55 with base r2=0x104, plus a simultaneous ALU write to r4 -> ld_ready=1, alu_ready=0; next cycle port1=r1/0x55, port2=r2/0x104; ALU r4 committed the following cycle.
- Load r5 and ALU r5 in the same cycle -> load r5 written first; ALU r5 written a cycle later; final r5 holds the ALU value.
- ALU flags-only with NZCV=1010 and cspr=0x000000D3 -> cspr_write=1, cspr_update=0xA00000D3, no GPR enables.
- Loads with base held back-to-back and alu_valid held for 4 cycles -> ALU accepted on the 5th cycle, counter cleared.
- ALU writes r15=0x200 -> pc_write=1, pc_update=0x200, flush=1 for exactly one cycle, GPR enables 0.
- rst_n asserted mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/regbank_writeback_ctrl.sv
// Write-side arbiter for the ARM register bank: merges ALU and load/store results onto two GPR
// ports, the PC port and the CSPR port. Optional forwarding port under `WBCTRL_BYPASS_EN.
module regbank_writeback_ctrl #(
    parameter int unsigned N          = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         alu_valid,
    output logic         alu_ready,
    input  logic [3:0]   alu_rd,
    input  logic [N-1:0] alu_data,
    input  logic         alu_wb,
    input  logic         alu_flags_we,
    input  logic [3:0]   alu_flags,

    input  logic         ld_valid,
    output logic         ld_ready,
    input  logic [3:0]   ld_rd,
    input  logic [N-1:0] ld_data,
    input  logic         ld_base_we,
    input  logic [3:0]   ld_base_rd,
    input  logic [N-1:0] ld_base_data,

    input  logic [N-1:0] cspr,

    output logic [3:0]   write_address,
    output logic [N-1:0] write_data,
    output logic         write_enable,
    output logic [3:0]   write_address2,
    output logic [N-1:0] write_data2,
    output logic         write_enable2,
    output logic [N-1:0] pc_update,
    output logic         pc_write,
    output logic [N-1:0] cspr_update,
    output logic         cspr_write,
`ifdef WBCTRL_BYPASS_EN
    input  logic [3:0]   byp_addr,
    output logic         byp_hit,
    output logic [N-1:0] byp_data,
`endif
    output logic         flush
);

    localparam int unsigned CW    = $clog2(STARVE_MAX + 1);
    localparam logic [3:0]  PcReg = 4'd15;

    logic [CW-1:0] starve_q, starve_d;
    logic [3:0]    wa1_q, wa1_d, wa2_q, wa2_d;
    logic [N-1:0]  wd1_q, wd1_d, wd2_q, wd2_d;
    logic          we1_q, we1_d, we2_q, we2_d;
    logic [N-1:0]  pc_q, pc_d, cspr_q, cspr_d;
    logic          pcw_q, pcw_d, csprw_q, csprw_d, flush_q, flush_d;

    logic ld_p1, ld_p2, ld_pc, alu_gpr, alu_pc, same_reg, both_ok, starved;
    logic ld_acc, alu_acc, alu_use_p2;

    // Upper CSPR bits are always replaced by the ALU flags.
    logic unused_cspr;
    assign unused_cspr = ^cspr[N-1:N-4];

    always_comb begin
        ld_p1    = (ld_rd != PcReg);
        ld_p2    = ld_base_we && (ld_base_rd != PcReg);
        ld_pc    = (ld_rd == PcReg) || (ld_base_we && (ld_base_rd == PcReg));
        alu_gpr  = alu_wb && (alu_rd != PcReg);
        alu_pc   = alu_wb && (alu_rd == PcReg);
        same_reg = alu_wb && ((alu_rd == ld_rd) || (ld_base_we && (alu_rd == ld_base_rd)));
        both_ok  = !(alu_gpr && ld_p1 && ld_p2) && !(alu_pc && ld_pc) && !same_reg;
        starved  = (starve_q == CW'(STARVE_MAX));

        if (starved) begin
            alu_acc = alu_valid;
            ld_acc  = ld_valid && (!alu_valid || both_ok);
        end else begin
            ld_acc  = ld_valid;
            alu_acc = alu_valid && (!ld_valid || both_ok);
        end
        alu_ready = alu_acc;
        ld_ready  = ld_acc;

        starve_d = starve_q;
        if (alu_acc) begin
            starve_d = '0;
        end else if (alu_valid && !starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        wa1_d   = '0;
        wd1_d   = '0;
        we1_d   = 1'b0;
        wa2_d   = '0;
        wd2_d   = '0;
        we2_d   = 1'b0;
        pc_d    = '0;
        pcw_d   = 1'b0;
        cspr_d  = '0;
        csprw_d = 1'b0;

        if (ld_acc) begin
            if (ld_p1) begin
                we1_d = 1'b1;
                wa1_d = ld_rd;
                wd1_d = ld_data;
            end
            if (ld_p2) begin
                we2_d = 1'b1;
                wa2_d = ld_base_rd;
                wd2_d = ld_base_data;
            end
            // Load data beats the base update when both target the PC.
            if (ld_rd == PcReg) begin
                pcw_d = 1'b1;
                pc_d  = ld_data;
            end else if (ld_base_we && (ld_base_rd == PcReg)) begin
                pcw_d = 1'b1;
                pc_d  = ld_base_data;
            end
        end

        alu_use_p2 = ld_acc && !ld_p2;
        if (alu_acc) begin
            if (alu_gpr) begin
                if (alu_use_p2) begin
                    we2_d = 1'b1;
                    wa2_d = alu_rd;
                    wd2_d = alu_data;
                end else begin
                    we1_d = 1'b1;
                    wa1_d = alu_rd;
                    wd1_d = alu_data;
                end
            end
            if (alu_pc) begin
                pcw_d = 1'b1;
                pc_d  = alu_data;
            end
            if (alu_flags_we) begin
                csprw_d = 1'b1;
                cspr_d  = {alu_flags, cspr[N-5:0]};
            end
        end
        flush_d = pcw_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            wa1_q    <= '0;
            wd1_q    <= '0;
            we1_q    <= 1'b0;
            wa2_q    <= '0;
            wd2_q    <= '0;
            we2_q    <= 1'b0;
            pc_q     <= '0;
            pcw_q    <= 1'b0;
            cspr_q   <= '0;
            csprw_q  <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            wa1_q    <= wa1_d;
            wd1_q    <= wd1_d;
            we1_q    <= we1_d;
            wa2_q    <= wa2_d;
            wd2_q    <= wd2_d;
            we2_q    <= we2_d;
            pc_q     <= pc_d;
            pcw_q    <= pcw_d;
            cspr_q   <= cspr_d;
            csprw_q  <= csprw_d;
            flush_q  <= flush_d;
        end
    end

    assign write_address  = wa1_q;
    assign write_data     = wd1_q;
    assign write_enable   = we1_q;
    assign write_address2 = wa2_q;
    assign write_data2    = wd2_q;
    assign write_enable2  = we2_q;
    assign pc_update      = pc_q;
    assign pc_write       = pcw_q;
    assign cspr_update    = cspr_q;
    assign cspr_write     = csprw_q;
    assign flush          = flush_q;

`ifdef WBCTRL_BYPASS_EN
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        if (we2_q && (wa2_q == byp_addr)) begin
            byp_hit  = 1'b1;
            byp_data = wd2_q;
        end else if (we1_q && (wa1_q == byp_addr)) begin
            byp_hit  = 1'b1;
            byp_data = wd1_q;
        end
    end
`endif

endmodule

// File: tb/tb_regbank_writeback_ctrl.sv
// Directed self-checking bench for regbank_writeback_ctrl.
module tb_regbank_writeback_ctrl;

    localparam int unsigned N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         alu_valid, alu_ready, alu_wb, alu_flags_we;
    logic [3:0]   alu_rd, alu_flags;
    logic [N-1:0] alu_data;
    logic         ld_valid, ld_ready, ld_base_we;
    logic [3:0]   ld_rd, ld_base_rd;
    logic [N-1:0] ld_data, ld_base_data, cspr;
    logic [3:0]   write_address, write_address2;
    logic [N-1:0] write_data, write_data2, pc_update, cspr_update;
    logic         write_enable, write_enable2, pc_write, cspr_write, flush;
`ifdef WBCTRL_BYPASS_EN
    logic [3:0]   byp_addr;
    logic         byp_hit;
    logic [N-1:0] byp_data;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regbank_writeback_ctrl #(.N(N), .STARVE_MAX(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .alu_wb         (alu_wb),
        .alu_flags_we   (alu_flags_we),
        .alu_flags      (alu_flags),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_rd          (ld_rd),
        .ld_data        (ld_data),
        .ld_base_we     (ld_base_we),
        .ld_base_rd     (ld_base_rd),
        .ld_base_data   (ld_base_data),
        .cspr           (cspr),
        .write_address  (write_address),
        .write_data     (write_data),
        .write_enable   (write_enable),
        .write_address2 (write_address2),
        .write_data2    (write_data2),
        .write_enable2  (write_enable2),
        .pc_update      (pc_update),
        .pc_write       (pc_write),
        .cspr_update    (cspr_update),
        .cspr_write     (cspr_write),
`ifdef WBCTRL_BYPASS_EN
        .byp_addr       (byp_addr),
        .byp_hit        (byp_hit),
        .byp_data       (byp_data),
`endif
        .flush          (flush)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0; alu_wb = 0; alu_flags_we = 0; alu_flags = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0; ld_base_we = 0; ld_base_rd = 0; ld_base_data = 0;
    endtask

    task automatic alu_req(input logic [3:0] rd, input logic [31:0] data);
        alu_valid = 1; alu_rd = rd; alu_data = data; alu_wb = 1; alu_flags_we = 0;
    endtask

    task automatic ld_req(input logic [3:0] rd, input logic [31:0] data, input logic bwe,
                          input logic [3:0] brd, input logic [31:0] bdata);
        ld_valid = 1; ld_rd = rd; ld_data = data;
        ld_base_we = bwe; ld_base_rd = brd; ld_base_data = bdata;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_we1"}, {31'b0, write_enable}, 0);
        check_eq({tag, "_we2"}, {31'b0, write_enable2}, 0);
        check_eq({tag, "_pcw"}, {31'b0, pc_write}, 0);
        check_eq({tag, "_flush"}, {31'b0, flush}, 0);
    endtask

    initial begin
        idle_inputs();
        cspr  = 32'h0000_00D3;
        rst_n = 0;
`ifdef WBCTRL_BYPASS_EN
        byp_addr = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_idle("rst");
        check_eq("rst_wd1", write_data, 0);
        check_eq("rst_wa1", {28'b0, write_address}, 0);
        check_eq("rst_cspr", {31'b0, cspr_write}, 0);
        rst_n = 1;

        // ALU alone to r3.
        alu_req(4'd3, 32'hA);
        #1 check_eq("t1_alu_rdy", {31'b0, alu_ready}, 1);
        tick(); idle_inputs();
        check_eq("t1_we1", {31'b0, write_enable}, 1);
        check_eq("t1_wa1", {28'b0, write_address}, 3);
        check_eq("t1_wd1", write_data, 32'hA);
        check_eq("t1_we2", {31'b0, write_enable2}, 0);
        tick();
        check_eq("t1_pulse", {31'b0, write_enable}, 0);

        // Load r1 + base r2 with ALU r4 competing.
        ld_req(4'd1, 32'h55, 1, 4'd2, 32'h104);
        alu_req(4'd4, 32'h44);
        #1 check_eq("t2_ld_rdy", {31'b0, ld_ready}, 1);
        check_eq("t2_alu_rdy", {31'b0, alu_ready}, 0);
        tick(); ld_valid = 0; ld_base_we = 0;
        check_eq("t2_wa1", {28'b0, write_address}, 1);
        check_eq("t2_wd1", write_data, 32'h55);
        check_eq("t2_wa2", {28'b0, write_address2}, 2);
        check_eq("t2_wd2", write_data2, 32'h104);
        check_eq("t2_we2", {31'b0, write_enable2}, 1);
        #1 check_eq("t2_alu_rdy2", {31'b0, alu_ready}, 1);
        tick(); idle_inputs();
        check_eq("t2_alu_we1", {31'b0, write_enable}, 1);
        check_eq("t2_alu_wa1", {28'b0, write_address}, 4);
        check_eq("t2_alu_wd1", write_data, 32'h44);

        // Same destination: load first, ALU next.
        ld_req(4'd5, 32'h111, 0, 4'd0, 0);
        alu_req(4'd5, 32'h222);
        #1 check_eq("t3_alu_rdy", {31'b0, alu_ready}, 0);
        tick(); ld_valid = 0;
        check_eq("t3_first", write_data, 32'h111);
        check_eq("t3_we2", {31'b0, write_enable2}, 0);
        tick(); idle_inputs();
        check_eq("t3_wa1", {28'b0, write_address}, 5);
        check_eq("t3_second", write_data, 32'h222);

        // Flags-only ALU.
        alu_valid = 1; alu_wb = 0; alu_flags_we = 1; alu_flags = 4'b1010;
        tick(); idle_inputs();
        check_eq("t4_csprw", {31'b0, cspr_write}, 1);
        check_eq("t4_cspru", cspr_update, 32'hA000_00D3);
        check_idle("t4");

        // Starvation: loads with base saturate both ports.
        ld_req(4'd6, 32'h66, 1, 4'd7, 32'h77);
        alu_req(4'd8, 32'h88);
        for (int i = 0; i < 4; i++) begin
            #1 check_eq($sformatf("t5_stall%0d", i), {31'b0, alu_ready}, 0);
            tick();
        end
        check_eq("t5_alu_win", {31'b0, alu_ready}, 1);
        check_eq("t5_ld_held", {31'b0, ld_ready}, 0);
        tick();
        check_eq("t5_wa1", {28'b0, write_address}, 8);
        check_eq("t5_wd1", write_data, 32'h88);
        check_eq("t5_we2", {31'b0, write_enable2}, 0);
        alu_data = 32'h99;
        #1 check_eq("t5_cleared", {31'b0, alu_ready}, 0);
        tick(); idle_inputs();

        // ALU to PC.
        alu_req(4'd15, 32'h200);
        tick(); idle_inputs();
        check_eq("t6_pcw", {31'b0, pc_write}, 1);
        check_eq("t6_pcu", pc_update, 32'h200);
        check_eq("t6_flush", {31'b0, flush}, 1);
        check_eq("t6_we1", {31'b0, write_enable}, 0);
        check_eq("t6_we2", {31'b0, write_enable2}, 0);
        tick();
        check_idle("t6_after");

        // PC conflict and load+base both to PC.
        ld_req(4'd15, 32'h300, 1, 4'd15, 32'h999);
        alu_req(4'd15, 32'h400);
        #1 check_eq("t7_alu_rdy", {31'b0, alu_ready}, 0);
        tick(); idle_inputs();
        check_eq("t7_pcu", pc_update, 32'h300);
        check_eq("t7_we2", {31'b0, write_enable2}, 0);
        tick();

        // Asynchronous reset mid-stream.
        alu_req(4'd3, 32'h5A5A);
        tick();
        check_eq("t8_pre", {31'b0, write_enable}, 1);
`ifdef WBCTRL_BYPASS_EN
        byp_addr = 4'd3;
        #1 check_eq("byp_hit", {31'b0, byp_hit}, 1);
        check_eq("byp_data", byp_data, 32'h5A5A);
`endif
        #2 rst_n = 0;
        #1;
        check_idle("t8");
        check_eq("t8_wd1", write_data, 0);
        idle_inputs();
        tick();
        rst_n = 1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
